argmax_classifier: RTL and testbench

- Sequential consumer of the final ReLU-activated logit vector (10 classes, LeNet output layer).
- Captures one vector on a valid/ready handshake and scans it one element per cycle.
- Returns the winning class index and its value on a valid/ready output handshake.
- Sits between the last activation stage and the result/host interface.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/argmax_classifier.sv | 107 ++++++++++
 tb/tb_argmax_classifier.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the LeNet inference pipeline.
// The argmax output stage uses the default element width, the class count and the state encoding from here.
package cnn_pkg;

    localparam int BITWIDTH    = 32;
    localparam int NUM_CLASSES = 10;

    typedef logic signed [BITWIDTH-1:0] logit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/argmax_classifier.sv
// Sequential argmax over the final activated logit vector.
// Accepts one vector, scans one element per cycle and hands back the winning class on a valid/ready pair.
module argmax_classifier #(
    parameter int  BITWIDTH    = cnn_pkg::BITWIDTH,
    parameter int  NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] featuremap [NUM_CLASSES-1:0],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           class_idx,
    output logic signed [BITWIDTH-1:0] class_val,
    output logic                       all_zero
);
    import cnn_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]                 state;
    logic signed [BITWIDTH-1:0] captured [NUM_CLASSES-1:0];
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           best_idx;
    logic signed [BITWIDTH-1:0] best_val;
    logic                       zero_acc;

    logic signed [BITWIDTH-1:0] cur_val;
    logic signed [BITWIDTH-1:0] next_val;
    logic [IDX_W-1:0]           next_idx;
    logic                       next_zero;
    logic                       last_elem;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // One signed comparator shared across the scan; strict '>' keeps the lowest index on ties.
    always_comb begin
        cur_val   = captured[idx];
        next_val  = best_val;
        next_idx  = best_idx;
        if (cur_val > best_val) begin
            next_val = cur_val;
            next_idx = idx;
        end
        next_zero = zero_acc && (cur_val == '0);
        last_elem = (idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            zero_acc  <= 1'b0;
            class_idx <= '0;
            class_val <= '0;
            all_zero  <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                captured[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // Element 0 seeds the running max so the scan starts at index 1.
                    if (in_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            captured[i] <= featuremap[i];
                        end
                        best_val <= featuremap[0];
                        best_idx <= '0;
                        zero_acc <= (featuremap[0] == '0);
                        idx      <= IDX_W'(1);
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best_val <= next_val;
                    best_idx <= next_idx;
                    zero_acc <= next_zero;
                    if (last_elem) begin
                        class_idx <= next_idx;
                        class_val <= next_val;
                        all_zero  <= next_zero;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed testbench for argmax_classifier: latency, ties, signed values, backpressure and mid-scan reset.
module tb_argmax_classifier;
    import cnn_pkg::*;

    localparam int NC = cnn_pkg::NUM_CLASSES;
    localparam int IW = $clog2(NC);

    typedef logic signed [31:0] vec_t [0:NC-1];

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [31:0]  featuremap [NC-1:0];
    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       class_idx;
    logic signed [31:0]  class_val;
    logic                all_zero;

    int checks;
    int failures;

    argmax_classifier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .featuremap (featuremap),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .class_idx  (class_idx),
        .class_val  (class_val),
        .all_zero   (all_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a vector and hold in_valid until the accept edge has passed.
    task automatic applyStimulus(input string tag, input vec_t vec);
        logic accepted;
        int   n;
        for (int i = 0; i < NC; i++) featuremap[i] = vec[i];
        in_valid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            accepted = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    // Called just after the accept edge; checks latency and the result fields.
    task automatic waitResult(input string tag, input bit scramble, input int exp_idx,
                              input logic [31:0] exp_val, input logic exp_zero);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            if (scramble) for (int i = 0; i < NC; i++) featuremap[i] = $urandom;
            step();
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd9);
        checkOutput({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
        checkOutput({tag, "_val"}, class_val, exp_val);
        checkOutput({tag, "_zero"}, 32'(all_zero), 32'(exp_zero));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        checkOutput({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t v_basic, v_tie, v_zero, v_last, v_neg;
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NC; i++) featuremap[i] = '0;

        v_basic = '{0, 5, 3, 9, 1, 0, 2, 7, 4, 8};
        v_tie   = '{4, 0, 7, 7, 1, 7, 0, 0, 0, 0};
        v_zero  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        v_last  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 32'h7FFFFFFF};
        v_neg   = '{-5, -2, -9, -1, -3, -7, -4, -6, -8, -10};

        rst_n = 1'b0;
        #13;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_class_idx", 32'(class_idx), 32'd0);
        checkOutput("rst_class_val", class_val, 32'd0);
        checkOutput("rst_all_zero", 32'(all_zero), 32'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] basic vector, out_ready held high");
        out_ready = 1'b1;
        applyStimulus("basic", v_basic);
        waitResult("basic", 1'b0, 3, 32'd9, 1'b0);
        handshake("basic");

        $display("[TB] tie keeps lowest index");
        applyStimulus("tie", v_tie);
        waitResult("tie", 1'b0, 2, 32'd7, 1'b0);
        handshake("tie");

        $display("[TB] all zeros");
        applyStimulus("zero", v_zero);
        waitResult("zero", 1'b0, 0, 32'd0, 1'b1);
        handshake("zero");

        $display("[TB] max at last element");
        applyStimulus("last", v_last);
        waitResult("last", 1'b0, 9, 32'h7FFFFFFF, 1'b0);
        handshake("last");

        $display("[TB] backpressure with a pending second vector");
        out_ready = 1'b0;
        applyStimulus("bp", v_basic);
        waitResult("bp", 1'b0, 3, 32'd9, 1'b0);
        for (int i = 0; i < NC; i++) featuremap[i] = v_tie[i];
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_idx", 32'(class_idx), 32'd3);
            checkOutput("bp_hold_val", class_val, 32'd9);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        handshake("bp");
        step();
        in_valid = 1'b0;
        checkOutput("bp_second_accepted", 32'(in_ready), 32'd0);
        waitResult("bp2", 1'b0, 2, 32'd7, 1'b0);
        handshake("bp2");

        $display("[TB] signed negatives");
        applyStimulus("neg", v_neg);
        waitResult("neg", 1'b0, 3, 32'hFFFFFFFF, 1'b0);
        handshake("neg");

        $display("[TB] featuremap scrambled during scan");
        applyStimulus("scr", v_basic);
        waitResult("scr", 1'b1, 3, 32'd9, 1'b0);
        handshake("scr");

        $display("[TB] reset pulse mid-scan");
        applyStimulus("rst", v_tie);
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_class_idx", 32'(class_idx), 32'd0);
        checkOutput("midrst_class_val", class_val, 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        applyStimulus("after_rst", v_last);
        waitResult("after_rst", 1'b0, 9, 32'h7FFFFFFF, 1'b0);
        handshake("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
